// File: rtl/spi_word_sequencer.sv
// spi_word_sequencer: FIFO-fed write/wait/read sequencer for the SPI master register port
// Optional WAIT_RX watchdog with timeout_err output when SPI_SEQ_TIMEOUT_EN is defined.
module spi_word_sequencer #(
  parameter int DATA_W      = 20,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              spi_select,
  output logic [2:0]        spi_mem_addr,
  output logic              spi_write_n,
  output logic              spi_read_n,
  output logic [31:0]       spi_wdata,
  input  logic [31:0]       spi_rdata,
  input  logic              spi_dataavail,
`ifdef SPI_SEQ_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic              busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] IDLE = 3'd0, WR1 = 3'd1, WR2 = 3'd2, WAIT_RX = 3'd3, RD1 = 3'd4, RD2 = 3'd5;
  logic [2:0]        state, nxt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, count;
  logic              push, pop, empty, tmo, nxt_wr, nxt_rd;
  logic              unused_rdata;
  assign unused_rdata = ^spi_rdata;
  assign count   = wr_ptr - rd_ptr;
  assign empty   = count == '0;
  assign s_ready = count != (AW+1)'(FIFO_DEPTH);
  assign push    = s_valid & s_ready;
  assign pop     = state == IDLE & ~empty & ~m_valid;
  assign busy    = state != IDLE | ~empty;
  assign nxt_wr  = nxt == WR1 | nxt == WR2;
  assign nxt_rd  = nxt == RD1 | nxt == RD2;
  always_comb begin
    nxt = state == IDLE    ? (pop ? WR1 : IDLE) :
          state == WR1     ? WR2 :
          state == WR2     ? WAIT_RX :
          state == WAIT_RX ? (spi_dataavail ? RD1 : tmo ? IDLE : WAIT_RX) :
          state == RD1     ? RD2 : IDLE;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      spi_select   <= 1'b0;
      spi_mem_addr <= 3'd0;
      spi_write_n  <= 1'b1;
      spi_read_n   <= 1'b1;
      spi_wdata    <= '0;
    end else begin
      state        <= nxt;
      wr_ptr       <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr       <= pop ? rd_ptr + 1'b1 : rd_ptr;
      spi_wdata    <= pop ? 32'(mem[rd_ptr[AW-1:0]]) : spi_wdata;
      spi_select   <= nxt_wr | nxt_rd;
      spi_mem_addr <= nxt_wr ? 3'd1 : 3'd0;
      spi_write_n  <= ~nxt_wr;
      spi_read_n   <= ~nxt_rd;
      m_data       <= state == RD2 ? spi_rdata[DATA_W-1:0] : m_data;
      m_valid      <= state == RD2 | (m_valid & ~m_ready);
    end
  end
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  assign tmo = state == WAIT_RX & tcnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      tcnt        <= (state == WAIT_RX & nxt == WAIT_RX) ? tcnt + 1'b1 : '0;
      timeout_err <= state == WAIT_RX & nxt == IDLE;
    end
  end
`else
  assign tmo = 1'b0;
`endif
endmodule

// File: tb/tb_spi_word_sequencer.sv
// tb_spi_word_sequencer: directed scoreboard bench with a loopback SPI master model
module tb_spi_word_sequencer;
  localparam int TMO = 64;
  localparam int LAT = 30;
  logic        clk = 0, reset = 1, s_valid = 0, m_ready = 0, hold_rx = 0;
  logic [19:0] s_data = '0;
  logic [19:0] m_data;
  logic        s_ready, m_valid, spi_select, spi_write_n, spi_read_n, busy;
  logic [2:0]  spi_mem_addr;
  logic [31:0] spi_wdata;
  logic [31:0] rdat = '0, shreg = '0;
  logic        dav = 0;
  int          dly = 0, wcnt = 0, rcnt = 0;
  int          ncmp = 0, nerr = 0, n_wr = 0, n_rd = 0, n_tmo = 0, wrun = 0, rrun = 0;
  bit          strobe_seen = 0;
  logic [19:0] sb[$];
  logic [19:0] wq[$];
`ifdef SPI_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  spi_word_sequencer #(.DATA_W(20), .FIFO_DEPTH(4), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .spi_select(spi_select), .spi_mem_addr(spi_mem_addr),
    .spi_write_n(spi_write_n), .spi_read_n(spi_read_n),
    .spi_wdata(spi_wdata), .spi_rdata(rdat), .spi_dataavail(dav),
`ifdef SPI_SEQ_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Loopback master: latches tx on the second write cycle, raises RRDY LAT cycles later, clears it on read.
  always @(posedge clk) begin
    if (reset) begin
      dav  <= 0;
      dly  <= 0;
      wcnt <= 0;
      rcnt <= 0;
    end else begin
      wcnt <= (!spi_write_n && spi_select && spi_mem_addr == 3'd1) ? wcnt + 1 : 0;
      rcnt <= (!spi_read_n && spi_select && spi_mem_addr == 3'd0) ? rcnt + 1 : 0;
      if (wcnt == 1 && !spi_write_n) begin
        shreg <= spi_wdata;
        dly   <= LAT;
      end else if (dly != 0) begin
        dly <= dly - 1;
        if (dly == 1 && !hold_rx) begin
          dav  <= 1;
          rdat <= {12'hA5A, shreg[19:0]};
        end
      end
      if (rcnt == 1 && !spi_read_n) dav <= 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mon;
    logic [19:0] e;
    if (!spi_write_n) begin
      if (wrun == 0) begin
        chk("wr_addr", 32'(spi_mem_addr), 1);
        chk("wr_sel", 32'(spi_select), 1);
        e = wq.size() != 0 ? wq.pop_front() : ~spi_wdata[19:0];
        chk("wr_data", spi_wdata, {12'h0, e});
      end
      wrun++;
    end else if (wrun != 0) begin
      chk("wr_len", wrun, 2);
      wrun = 0;
      n_wr++;
    end
    if (!spi_read_n) begin
      if (rrun == 0) begin
        chk("rd_addr", 32'(spi_mem_addr), 0);
        chk("rd_sel", 32'(spi_select), 1);
      end
      rrun++;
    end else if (rrun != 0) begin
      chk("rd_len", rrun, 2);
      rrun = 0;
      n_rd++;
    end
    if (!spi_write_n || !spi_read_n || spi_select) strobe_seen = 1;
    if (m_valid && m_ready) begin
      e = sb.size() != 0 ? sb.pop_front() : ~m_data;
      chk("m_data", 32'(m_data), 32'(e));
    end
`ifdef SPI_SEQ_TIMEOUT_EN
    if (timeout_err) begin
      n_tmo++;
      if (sb.size() != 0) void'(sb.pop_front());
    end
`endif
    if (s_valid && s_ready) begin
      sb.push_back(s_data);
      wq.push_back(s_data);
    end
  endtask

  task automatic cyc;
    mon();
    @(negedge clk);
  endtask

  task automatic drain;
    for (int i = 0; i < 3000 && (busy || m_valid || sb.size() != 0); i++) cyc();
    chk("drain", {29'h0, busy, m_valid, sb.size() == 0}, 32'b001);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 400 && !m_valid; i++) cyc();
    chk(tag, 32'(m_valid), 1);
  endtask

  logic [19:0] w3 [5] = '{20'h11111, 20'h22222, 20'h33333, 20'h44444, 20'h55555};
  logic [19:0] w4 [2] = '{20'h0BEEF, 20'hFACE1};

  initial begin
    int c, prev;
    @(negedge clk);
    repeat (3) cyc();
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_select", 32'(spi_select), 0);
    chk("rst_write_n", 32'(spi_write_n), 1);
    chk("rst_read_n", 32'(spi_read_n), 1);
    chk("rst_addr", 32'(spi_mem_addr), 0);
    chk("rst_wdata", spi_wdata, 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 0;
    strobe_seen = 0;
    repeat (100) cyc();
    chk("idle_strobes", 32'(strobe_seen), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_s_ready", 32'(s_ready), 1);

    m_ready = 1;
    s_valid = 1;
    s_data  = 20'hABCDE;
    cyc();
    s_valid = 0;
    chk("t2_busy", 32'(busy), 1);
    wait_valid("t2_m_valid");
    chk("t2_m_data", 32'(m_data), 32'h000ABCDE);
    drain();
    chk("t2_writes", n_wr, 1);
    chk("t2_reads", n_rd, 1);

    for (int k = 0; k < 5; k++) begin
      s_valid = 1;
      s_data  = w3[k];
      chk("t3_ready_before_push", 32'(s_ready), 1);
      cyc();
    end
    s_valid = 0;
    chk("t3_full", 32'(s_ready), 0);
    chk("t3_busy", 32'(busy), 1);
    drain();
    chk("t3_writes", n_wr, 6);
    chk("t3_reads", n_rd, 6);

    m_ready = 0;
    for (int k = 0; k < 2; k++) begin
      s_valid = 1;
      s_data  = w4[k];
      cyc();
    end
    s_valid = 0;
    wait_valid("t4_first_valid");
    repeat (40) cyc();
    chk("t4_hold_valid", 32'(m_valid), 1);
    chk("t4_hold_data", 32'(m_data), 32'(w4[0]));
    chk("t4_no_second_write", n_wr, 7);
    chk("t4_fifo_pending", 32'(busy), 1);
    m_ready = 1;
    cyc();
    m_ready = 0;
    wait_valid("t4_second_valid");
    chk("t4_second_data", 32'(m_data), 32'(w4[1]));
    m_ready = 1;
    drain();
    chk("t4_writes", n_wr, 8);

    for (int k = 0; k < 2; k++) begin
      s_valid = 1;
      s_data  = 20'h12340 + 20'(k);
      cyc();
    end
    s_valid = 0;
    for (int i = 0; i < 100 && n_wr != 9; i++) cyc();
    chk("t5_first_write", n_wr, 9);
    repeat (3) cyc();
    prev  = n_rd;
    reset = 1;
    cyc();
    chk("t5_busy", 32'(busy), 0);
    chk("t5_m_valid", 32'(m_valid), 0);
    chk("t5_write_n", 32'(spi_write_n), 1);
    chk("t5_read_n", 32'(spi_read_n), 1);
    chk("t5_select", 32'(spi_select), 0);
    chk("t5_s_ready", 32'(s_ready), 1);
    sb.delete();
    wq.delete();
    reset   = 0;
    s_valid = 1;
    s_data  = 20'h5A5A5;
    cyc();
    s_valid = 0;
    drain();
    chk("t5_reads_after", n_rd, prev + 1);
    chk("t5_no_stale_write", n_wr, 10);

`ifdef SPI_SEQ_TIMEOUT_EN
    hold_rx = 1;
    s_valid = 1;
    s_data  = 20'h0F0F0;
    cyc();
    s_valid = 0;
    for (int i = 0; i < 20 && spi_write_n; i++) cyc();
    c = 0;
    while (!timeout_err && c < 200) begin
      cyc();
      c++;
    end
    chk("t6_latency", c, TMO + 2);
    cyc();
    chk("t6_pulse_width", 32'(timeout_err), 0);
    chk("t6_idle", 32'(busy), 0);
    chk("t6_count", n_tmo, 1);
    chk("t6_reads", n_rd, prev + 1);
    hold_rx = 0;
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
